ram_fifo_ctrl: RTL and testbench

//  Turns the single-port 32x32 RAM macro into a valid/ready FIFO. Sits directly upstream of the RAM:

---
 rtl/ram_fifo_ctrl.sv | 66 ++++++
 tb/tb_ram_fifo_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO built around a single-port RAM with registered read data plus a one-word output stage
module ram_fifo_ctrl #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_WIDTH-1:0]    s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [DATA_WIDTH-1:0]    m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [ADDRESS_WIDTH:0]   level_o,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]    ram_data_o,
  output logic                     ram_we_o,
  input  logic [DATA_WIDTH-1:0]    ram_data_i
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] FULL = (ADDRESS_WIDTH + 1)'(DEPTH);
  logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDRESS_WIDTH:0]   ram_count;
  logic                     rd_pending, out_valid, last_rd;
  logic [DATA_WIDTH-1:0]    out_reg;
  logic                     pop, rd_want, wr_want, rd_grant, wr_grant;
  // arbitration of the single RAM port and the stream handshakes
  always_comb begin
    m_valid_o  = out_valid | rd_pending;
    m_data_o   = out_valid ? out_reg : ram_data_i;
    pop        = m_valid_o & m_ready_i;
    rd_want    = (ram_count != '0) & (!m_valid_o | pop);
    wr_want    = !rst_i & s_valid_i & (ram_count != FULL);
    rd_grant   = rd_want & (!wr_want | !last_rd);
    wr_grant   = wr_want & !rd_grant;
    s_ready_o  = !rst_i & (ram_count != FULL) & !rd_grant;
    ram_we_o   = wr_grant;
    ram_addr_o = wr_grant ? wr_ptr : rd_ptr;
    ram_data_o = s_data_i;
    level_o    = ram_count + (ADDRESS_WIDTH + 1)'(m_valid_o);
  end
  // pointers, occupancy, output stage capture and round-robin history
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_count  <= '0;
      rd_pending <= 1'b0;
      out_valid  <= 1'b0;
      out_reg    <= '0;
      last_rd    <= 1'b1;
    end else begin
      if (wr_grant) wr_ptr <= wr_ptr + 1'b1;
      if (rd_grant) rd_ptr <= rd_ptr + 1'b1;
      if (wr_grant) ram_count <= ram_count + 1'b1;
      else if (rd_grant) ram_count <= ram_count - 1'b1;
      rd_pending <= rd_grant;
      if (pop) out_valid <= 1'b0;
      else if (rd_pending) begin
        out_valid <= 1'b1;
        out_reg   <= ram_data_i;
      end
      if (rd_want & wr_want) last_rd <= rd_grant;
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed vector table plus multi-cycle sequences with a scoreboard for ram_fifo_ctrl
module tb_ram_fifo_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  logic clk = 0, rst = 1;
  logic [DW-1:0] s_data, m_data, ram_wdata, ram_q;
  logic s_valid, s_ready, m_valid, m_ready, ram_we;
  logic [AW:0] level;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q [$];
  int errors = 0, checks = 0, pushes = 0, pops = 0;

  typedef struct {
    logic sv; logic [DW-1:0] d; logic mr;
    logic rdy; logic mv; logic [DW-1:0] md; logic [AW:0] lvl; logic we; logic [AW-1:0] addr;
  } vec_t;
  vec_t vt [10];

  ram_fifo_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready), .level_o(level),
    .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_we_o(ram_we), .ram_data_i(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    #4;
    if (s_valid && s_ready) begin
      q.push_back(s_data);
      pushes++;
    end
    if (m_valid && m_ready) begin
      pops++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got pop of %0h expected no data", m_data);
      end else chk("sb_data", m_data, q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    s_valid = 0;
    m_ready = 0;
    s_data = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    pushes = 0;
    pops = 0;
  endtask

  initial begin
    logic [DW-1:0] d0;
    int acc, guard, exp_v, p0, w0;
    logic a, prev_we;
    vt[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0,        7'(0), 1'b1, 5'd0};
    vt[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        7'(1), 1'b0, 5'd0};
    vt[2] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 7'(1), 1'b0, 5'd1};
    vt[3] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 7'(1), 1'b0, 5'd1};
    vt[4] = '{1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0, 32'h0,        7'(0), 1'b1, 5'd1};
    vt[5] = '{1'b1, 32'h22222222, 1'b1, 1'b1, 1'b0, 32'h0,        7'(1), 1'b1, 5'd2};
    vt[6] = '{1'b1, 32'h33333333, 1'b1, 1'b0, 1'b0, 32'h0,        7'(2), 1'b0, 5'd1};
    vt[7] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h11111111, 7'(2), 1'b0, 5'd2};
    vt[8] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h22222222, 7'(1), 1'b0, 5'd3};
    vt[9] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        7'(0), 1'b0, 5'd3};
    s_valid = 1;
    m_ready = 1;
    s_data = 32'h5;
    #2;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", level, 0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      s_valid = vt[i].sv;
      s_data = vt[i].d;
      m_ready = vt[i].mr;
      #1;
      chk($sformatf("v%0d_s_ready", i), s_ready, vt[i].rdy);
      chk($sformatf("v%0d_m_valid", i), m_valid, vt[i].mv);
      if (vt[i].mv) chk($sformatf("v%0d_m_data", i), m_data, vt[i].md);
      chk($sformatf("v%0d_level", i), level, vt[i].lvl);
      chk($sformatf("v%0d_we", i), ram_we, vt[i].we);
      chk($sformatf("v%0d_addr", i), ram_addr, vt[i].addr);
      tick();
    end
    do_reset();
    acc = 0;
    s_valid = 1;
    for (int c = 0; c < 60; c++) begin
      s_data = acc;
      #1;
      a = s_ready;
      if (level == 7'(DEPTH + 1)) chk("full_no_we", ram_we, 0);
      tick();
      if (a) acc++;
    end
    chk("full_accepted", acc, 33);
    chk("full_s_ready", s_ready, 0);
    chk("full_level", level, 33);
    s_valid = 0;
    m_ready = 0;
    d0 = m_data;
    chk("stall_first", d0, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, d0);
    end
    m_ready = 1;
    exp_v = 0;
    guard = 0;
    while (exp_v < 33 && guard < 200) begin
      #1;
      if (m_valid) begin
        chk("drain_data", m_data, exp_v);
        exp_v++;
      end
      tick();
      guard++;
    end
    chk("drain_count", exp_v, 33);
    chk("drain_level", level, 0);
    do_reset();
    acc = 0;
    guard = 0;
    s_valid = 1;
    while (level != 7'(10) && guard < 50) begin
      s_data = 32'h1000 + acc;
      #1;
      a = s_ready;
      tick();
      if (a) acc++;
      guard++;
    end
    chk("alt_fill_level", level, 10);
    m_ready = 1;
    for (int c = 0; c < 4; c++) begin
      s_data = 32'h1000 + acc;
      #1;
      a = s_ready;
      tick();
      if (a) acc++;
    end
    p0 = pops;
    w0 = pushes;
    prev_we = ram_we;
    for (int c = 0; c < 12; c++) begin
      s_data = 32'h1000 + acc;
      #1;
      a = s_ready;
      if (c > 0) chk("alt_we_toggle", ram_we, !prev_we);
      prev_we = ram_we;
      chk("alt_level", level, 10);
      tick();
      if (a) acc++;
    end
    chk("alt_pops", pops - p0, 6);
    chk("alt_pushes", pushes - w0, 6);
    do_reset();
    acc = 0;
    guard = 0;
    while (pops < 200 && guard < 5000) begin
      s_valid = (acc < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_data = acc;
      m_ready = 1'($urandom_range(0, 1));
      #1;
      a = s_valid & s_ready;
      tick();
      if (a) acc++;
      guard++;
    end
    chk("rand_pops", pops, 200);
    chk("rand_pushes", pushes, 200);
    chk("rand_sb_empty", q.size(), 0);
    do_reset();
    acc = 0;
    guard = 0;
    s_valid = 1;
    while (level != 7'(12) && guard < 50) begin
      s_data = 32'h2000 + acc;
      #1;
      a = s_ready;
      tick();
      if (a) acc++;
      guard++;
    end
    chk("mid_level", level, 12);
    #3;
    rst = 1;
    #1;
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_we", ram_we, 0);
    #13;
    rst = 0;
    q.delete();
    pushes = 0;
    pops = 0;
    s_valid = 0;
    @(posedge clk);
    #1;
    chk("restart_level", level, 0);
    s_valid = 1;
    s_data = 32'hCAFE0001;
    m_ready = 1;
    tick();
    s_valid = 0;
    for (int c = 0; c < 4; c++) tick();
    chk("restart_pops", pops, 1);
    chk("restart_level_end", level, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
